// File: rtl/nba_grader.sv
// Number-baseball grader: latches a secret 4-digit answer at reset, grades each
// solver guess into strike/ball counts and ends the round on a hit or at MAX_CNT.
module nba_grader #(
  parameter int MAX_CNT = 200,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      answer,
  input  logic [15:0]      question,
  input  logic             ask_valid,
  output logic             ask_ready,
  output logic [2:0]       strike,
  output logic [2:0]       ball,
  output logic [CNT_W-1:0] cnt,
  output logic             reply_valid,
  input  logic             reply_ready,
  output logic             correct,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // A source holds its payload and valid until that edge; ready never waits on valid.
  typedef enum logic [1:0] {
    ASK   = 2'd0,
    EVAL  = 2'd1,
    REPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] answer_q;
  logic [15:0] q_reg;
  logic [2:0]  strike_c;
  logic [2:0]  ball_c;
  logic        accept;
  logic        last_q;

  assign state_dbg = state;
  assign accept    = ask_valid && ask_ready;
  assign last_q    = correct || (cnt == CNT_W'(MAX_CNT));

  // Distinct answer digits bound strike+ball to 4, so 3-bit sums suffice.
  always_comb begin
    strike_c = 3'd0;
    ball_c   = 3'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (q_reg[4*i +: 4] == answer_q[4*j +: 4]) begin
          if (i == j) strike_c = strike_c + 3'd1;
          else        ball_c   = ball_c + 3'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ask_ready   = 1'b0;
    reply_valid = 1'b0;
    case (state)
      ASK: begin
        ask_ready = reset;
        if (ask_valid) state_nxt = EVAL;
      end
      EVAL: state_nxt = REPLY;
      REPLY: begin
        reply_valid = reset;
        if (reply_ready) state_nxt = last_q ? DONE : ASK;
      end
      DONE: state_nxt = DONE;
      default: state_nxt = ASK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ASK;
      answer_q <= answer;
      q_reg    <= 16'h0000;
      cnt      <= '0;
      strike   <= 3'd0;
      ball     <= 3'd0;
      correct  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        q_reg <= question;
        cnt   <= cnt + CNT_W'(1);
      end
      if (state == EVAL) begin
        strike  <= strike_c;
        ball    <= ball_c;
        correct <= correct || (strike_c == 3'd4);
      end
    end
  end

endmodule

// File: tb/tb_nba_grader.sv
// Bench for nba_grader: table-driven guesses, random distinct-digit rounds and
// hand-written sequences for backpressure, round limit, mid-reply reset and streaming.
module tb_nba_grader;
  localparam int CNT_W   = 16;
  localparam int MAX_CNT = 200;
  localparam int W       = 3 + 3 + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [15:0]      answer = 16'h0000;
  logic [15:0]      question = 16'h0000;
  logic             ask_valid = 1'b0;
  logic             ask_ready;
  logic [2:0]       strike;
  logic [2:0]       ball;
  logic [CNT_W-1:0] cnt;
  logic             reply_valid;
  logic             reply_ready = 1'b0;
  logic             correct;
  logic [1:0]       state_dbg;

  nba_grader #(.MAX_CNT(MAX_CNT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .answer(answer), .question(question),
    .ask_valid(ask_valid), .ask_ready(ask_ready), .strike(strike), .ball(ball),
    .cnt(cnt), .reply_valid(reply_valid), .reply_ready(reply_ready),
    .correct(correct), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         failed = 0;
  int         exp_cnt = 0;
  logic       round_done = 1'b0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [15:0] ans;
    logic [15:0] q;
    logic [2:0]  s;
    logic [2:0]  b;
    int          hold;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] ans);
    @(posedge clk); #1;
    reset = 1'b0; answer = ans; ask_valid = 1'b0; reply_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_ask_ready", ask_ready, 0);
    check("rst_reply_valid", reply_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_strike_ball", {strike, ball}, 0);
    check("rst_correct", correct, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    answer = 16'hFFFF;  // grading must use the answer captured during reset
    exp_cnt = 0;
    round_done = 1'b0;
  endtask

  task automatic ask(input logic [15:0] q, input logic [2:0] s, input logic [2:0] b, input int hold);
    int n;
    logic [W-1:0] e;
    question = q;
    ask_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ask_ready && n < 20) begin n++; @(negedge clk); end
    if (!ask_ready) begin
      check("ask_ready_timeout", 0, 1);
      ask_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_cnt++;
    exp_q.push_back({s, b, (s == 3'd4), CNT_W'(exp_cnt)});
    #1;
    ask_valid = 1'b0;
    question = ~q;
    n = 1;
    @(negedge clk);
    while (!reply_valid && n < 10) begin n++; @(negedge clk); end
    check("reply_latency", n, 2);
    e = exp_q.pop_front();
    check("reply", {strike, ball, correct, cnt}, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", reply_valid, 1);
      check("hold_data", {strike, ball, correct, cnt}, e);
    end
    reply_ready = 1'b1;
    @(posedge clk); #1;
    reply_ready = 1'b0;
    if (s == 3'd4 || exp_cnt == MAX_CNT) round_done = 1'b1;
  endtask

  task automatic check_done(input logic exp_corr);
    @(negedge clk);
    check("done_ask_ready", ask_ready, 0);
    check("done_reply_valid", reply_valid, 0);
    check("done_correct", correct, exp_corr);
    check("done_cnt", cnt, exp_cnt);
    question = 16'h5555;
    ask_valid = 1'b1;
    reply_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("done_no_accept", {ask_ready, reply_valid}, 0);
    check("done_cnt_held", cnt, exp_cnt);
    ask_valid = 1'b0;
    reply_ready = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    int d[10];
    int k;
    int t;
    logic [15:0] r;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 9; i > 0; i--) begin
      k = $urandom_range(0, i);
      t = d[i]; d[i] = d[k]; d[k] = t;
    end
    r = {d[0][3:0], d[1][3:0], d[2][3:0], d[3][3:0]};
    return r;
  endfunction

  // Strike by position; ball as shared digits minus strikes (distinct digits only).
  function automatic void grade(input logic [15:0] a, input logic [15:0] q,
                                output logic [2:0] s, output logic [2:0] b);
    int st;
    int common;
    st = 0;
    common = 0;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] == q[4*i +: 4]) st++;
      for (int j = 0; j < 4; j++)
        if (a[4*i +: 4] == q[4*j +: 4]) common++;
    end
    s = 3'(st);
    b = 3'(common - st);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur_ans;
    logic [15:0] rq;
    logic [2:0]  rs;
    logic [2:0]  rb;
    int          acc;
    int          n;

    vecs[0]  = '{16'h1234, 16'h4321, 3'd0, 3'd4, 0};
    vecs[1]  = '{16'h1234, 16'h5678, 3'd0, 3'd0, 0};
    vecs[2]  = '{16'h1234, 16'h1243, 3'd2, 3'd2, 5};
    vecs[3]  = '{16'h1234, 16'h1111, 3'd1, 3'd3, 0};
    vecs[4]  = '{16'h1234, 16'h1235, 3'd3, 3'd0, 1};
    vecs[5]  = '{16'h1234, 16'h2134, 3'd2, 3'd2, 0};
    vecs[6]  = '{16'h1234, 16'h1234, 3'd4, 3'd0, 0};
    vecs[7]  = '{16'h1234, 16'h1234, 3'd4, 3'd0, 2};
    vecs[8]  = '{16'h9876, 16'h6789, 3'd0, 3'd4, 0};
    vecs[9]  = '{16'hABCD, 16'hDCBA, 3'd0, 3'd4, 0};
    vecs[10] = '{16'hABCD, 16'hABCE, 3'd3, 3'd0, 0};
    vecs[11] = '{16'hABCD, 16'hABCD, 3'd4, 3'd0, 0};

    repeat (2) @(posedge clk);
    cur_ans = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || vecs[i].ans != cur_ans || round_done) begin
        do_reset(vecs[i].ans);
        cur_ans = vecs[i].ans;
      end
      ask(vecs[i].q, vecs[i].s, vecs[i].b, vecs[i].hold);
      if (vecs[i].s == 3'd4) check_done(1'b1);
    end

    // Random rounds with distinct digits on both sides.
    cur_ans = rand_digits();
    do_reset(cur_ans);
    for (int i = 0; i < 20; i++) begin
      if (round_done) do_reset(cur_ans);
      rq = (i % 7 == 6) ? cur_ans : rand_digits();
      grade(cur_ans, rq, rs, rb);
      ask(rq, rs, rb, $urandom_range(0, 2));
    end

    // Round limit: MAX_CNT wrong guesses end the round.
    do_reset(16'h0123);
    for (int i = 0; i < MAX_CNT; i++) ask(16'h4567, 3'd0, 3'd0, 0);
    check("limit_cnt", exp_cnt, MAX_CNT);
    check_done(1'b0);

    // Reset during REPLY aborts the round and recaptures the answer.
    do_reset(16'h1234);
    question = 16'h5678;
    ask_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ask_ready && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    ask_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!reply_valid && n < 10) begin n++; @(negedge clk); end
    check("abort_in_reply", reply_valid, 1);
    reset = 1'b0;
    answer = 16'h9876;
    reply_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_reply_valid", reply_valid, 0);
    check("abort_cnt", cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    reply_ready = 1'b0;
    answer = 16'h0000;
    exp_cnt = 0;
    round_done = 1'b0;
    ask(16'h9876, 3'd4, 3'd0, 0);
    check_done(1'b1);

    // Streaming solver: one accept every three cycles.
    do_reset(16'h1234);
    question = 16'h5678;
    ask_valid = 1'b1;
    reply_ready = 1'b1;
    acc = 0;
    repeat (30) begin
      @(negedge clk);
      if (ask_valid && ask_ready) acc++;
      @(posedge clk);
    end
    #1;
    ask_valid = 1'b0;
    reply_ready = 1'b0;
    @(negedge clk);
    check("stream_accepts", acc, 10);
    check("stream_cnt", cnt, 10);
    check("stream_grade", {strike, ball}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
